pow_int_seq: RTL and testbench

POW_INT_SEQ -- requirements
Module: pow_int_seq

---
 rtl/pow_int_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_pow_int_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pow_int_seq.sv
// pow_int_seq: computes base^int(expo) by left-to-right square-and-multiply on a shared fp32 multiplier.
// Optional multiplier watchdog is compiled in with POW_MUL_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; result/frac_out/err hold last outcome
// SPLIT | waiting SPLIT_LAT cycles for the external int/frac splitter
// LOAD  | sample splitter, acc = base, index = msb(int) - 1
// SQR   | acc = acc * acc via multiplier handshake
// MUL   | acc = acc * base via multiplier handshake
// DONE  | one-cycle done pulse, result/frac_out/err valid
module pow_int_seq #(
    parameter int SPLIT_LAT = 1,
    parameter int INT_W     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base,
    input  logic [31:0] expo,
    output logic [31:0] split_ip,
    input  logic [31:0] split_int,
    input  logic [31:0] split_frac,
    output logic        mul_req,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ack,
    input  logic [31:0] mul_p,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [31:0] frac_out
);

    localparam int IDX_W = (INT_W > 1) ? $clog2(INT_W) : 1;
    localparam int LAT_W = 16;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((SPLIT_LAT > 1) ? SPLIT_LAT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPLIT = 3'd1,
        LOAD  = 3'd2,
        SQR   = 3'd3,
        MUL   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        base_q, base_d;
    logic [31:0]        expo_q, expo_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [INT_W-1:0]   int_q, int_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        frac_q, frac_d;
    logic               req_q, req_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               err_q, err_d;
    logic [31:0]        result_q, result_d;
    logic [31:0]        frac_out_q, frac_out_d;

`ifdef POW_MUL_TIMEOUT_EN
    // Loaded with 62 so the request stays up for exactly 63 unanswered cycles.
    localparam logic [5:0] WD_LOAD = 6'd62;
    logic [5:0]         wd_q, wd_d;
`endif

    logic               expo_bad;
    logic [IDX_W-1:0]   msb;
    logic               msb_vld;
    logic               finish;
    logic               finish_err;
    logic [31:0]        finish_val;
    logic               unused_split;

    assign unused_split = ^split_int[31:INT_W];

    assign expo_bad = expo[31] | (expo[30:23] < 8'd128) | (expo[30:23] > 8'd133);

    always_comb begin
        msb     = '0;
        msb_vld = 1'b0;
        for (int i = 0; i < INT_W; i++) begin
            if (split_int[i]) begin
                msb     = IDX_W'(i);
                msb_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        expo_d     = expo_q;
        lat_d      = lat_q;
        int_d      = int_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        frac_d     = frac_q;
        req_d      = req_q;
        a_d        = a_q;
        b_d        = b_q;
        err_d      = err_q;
        result_d   = result_q;
        frac_out_d = frac_out_q;
        finish     = 1'b0;
        finish_err = 1'b0;
        finish_val = '0;
`ifdef POW_MUL_TIMEOUT_EN
        wd_d       = wd_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = base;
                    expo_d     = expo;
                    lat_d      = LAT_LOAD;
                    err_d      = 1'b0;
                    result_d   = '0;
                    frac_out_d = '0;
                    if (expo_bad) begin
                        finish     = 1'b1;
                        finish_err = 1'b1;
                    end else begin
                        state_d = SPLIT;
                    end
                end
            end

            SPLIT: begin
                if (lat_q == '0) begin
                    state_d = LOAD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            LOAD: begin
                int_d  = split_int[INT_W-1:0];
                frac_d = split_frac;
                acc_d  = base_q;
                // A zero integer part has no defined power here; report it as an error.
                if (!msb_vld) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (msb == '0) begin
                    finish     = 1'b1;
                    finish_val = base_q;
                end else begin
                    idx_d   = msb - IDX_W'(1);
                    state_d = SQR;
                end
            end

            SQR, MUL: begin
                if (!req_q) begin
                    req_d = 1'b1;
                    a_d   = acc_q;
                    b_d   = (state_q == SQR) ? acc_q : base_q;
`ifdef POW_MUL_TIMEOUT_EN
                    wd_d  = WD_LOAD;
`endif
                end else if (mul_ack) begin
                    req_d = 1'b0;
                    acc_d = mul_p;
                    if ((state_q == SQR) && int_q[idx_q]) begin
                        state_d = MUL;
                    end else if (idx_q == '0) begin
                        finish     = 1'b1;
                        finish_val = mul_p;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = SQR;
                    end
                end
`ifdef POW_MUL_TIMEOUT_EN
                else if (wd_q == '0) begin
                    req_d      = 1'b0;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    wd_d = wd_q - 6'd1;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d    = DONE;
            err_d      = finish_err;
            result_d   = finish_err ? 32'd0 : finish_val;
            frac_out_d = finish_err ? 32'd0 : frac_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            expo_q     <= '0;
            lat_q      <= '0;
            int_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            frac_q     <= '0;
            req_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            err_q      <= 1'b0;
            result_q   <= '0;
            frac_out_q <= '0;
`ifdef POW_MUL_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            expo_q     <= expo_d;
            lat_q      <= lat_d;
            int_q      <= int_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            frac_q     <= frac_d;
            req_q      <= req_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_q      <= err_d;
            result_q   <= result_d;
            frac_out_q <= frac_out_d;
`ifdef POW_MUL_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign split_ip = expo_q;
    assign mul_req  = req_q;
    assign mul_a    = a_q;
    assign mul_b    = b_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign result   = result_q;
    assign frac_out = frac_out_q;

endmodule

// File: tb/tb_pow_int_seq.sv
// Testbench for pow_int_seq: directed vector table plus hand-written sequences for
// restart-while-busy, random multiplier latency, reset mid-multiply and the stalled multiplier.
module tb_pow_int_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] expo = '0;
    logic [31:0] split_ip;
    logic [31:0] split_int = '0;
    logic [31:0] split_frac = '0;
    logic        mul_req;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ack = 1'b0;
    logic [31:0] mul_p = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] result;
    logic [31:0] frac_out;

    pow_int_seq #(.SPLIT_LAT(1), .INT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .expo      (expo),
        .split_ip  (split_ip),
        .split_int (split_int),
        .split_frac(split_frac),
        .mul_req   (mul_req),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ack   (mul_ack),
        .mul_p     (mul_p),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .result    (result),
        .frac_out  (frac_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // fp32 <-> real for normal numbers (exact for the powers used here)
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // splitter model: one cycle latency, garbage unless split_ip is the expected expo
    logic [31:0] cur_expo = '0;
    logic [31:0] cur_int  = '0;
    logic [31:0] cur_frac = '0;

    always @(posedge clk) begin
        split_int  <= (split_ip == cur_expo) ? cur_int  : 32'hFFFF_FFFF;
        split_frac <= (split_ip == cur_expo) ? cur_frac : 32'h7FC0_0000;
    end

    // multiplier model with programmable latency and an ack budget
    int max_delay  = 0;
    int ack_budget = -1;
    int ack_base   = 0;
    int ack_total  = 0;
    int ack_wait   = 0;
    logic inject_ack = 1'b0;

    always @(posedge clk) begin
        mul_ack <= 1'b0;
        if (inject_ack) begin
            mul_ack <= 1'b1;
            mul_p   <= 32'h1234_5678;
        end else if (mul_req && !mul_ack &&
                     (ack_budget < 0 || (ack_total - ack_base) < ack_budget)) begin
            if (ack_wait == 0) begin
                mul_ack   <= 1'b1;
                mul_p     <= r2f(f2r(mul_a) * f2r(mul_b));
                ack_total <= ack_total + 1;
                ack_wait  <= (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
            end else begin
                ack_wait <= ack_wait - 1;
            end
        end
    end

    // protocol monitor: request counts, handshake counts and handshake rule violations
    int req_total = 0;
    int hs_total  = 0;
    int prot_err  = 0;
    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_done = 1'b0;
    logic [31:0] p_a = '0;
    logic [31:0] p_b = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_req  <= 1'b0;
            p_ack  <= 1'b0;
            p_done <= 1'b0;
        end else begin
            if (mul_req && !p_req) req_total <= req_total + 1;
            if (mul_req && mul_ack) hs_total <= hs_total + 1;
            if (p_req && !p_ack && mul_req && (mul_a != p_a || mul_b != p_b)) prot_err <= prot_err + 1;
            if (p_req && !p_ack && !mul_req && !(done && err)) prot_err <= prot_err + 1;
            if (p_req && p_ack && mul_req) prot_err <= prot_err + 1;
            if (done && p_done) prot_err <= prot_err + 1;
            p_req  <= mul_req;
            p_ack  <= mul_ack;
            p_done <= done;
            p_a    <= mul_a;
            p_b    <= mul_b;
        end
    end

    typedef struct {
        logic [31:0] base;
        logic [31:0] expo;
        logic [31:0] sint;
        logic [31:0] sfrac;
        logic        err;
        logic [31:0] res;
        logic [31:0] frac;
        int          n_mul;
    } vec_t;

    vec_t vecs[10];

    task automatic set_vec(input int i, input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] si, input logic [31:0] sf, input logic er,
                           input logic [31:0] r, input logic [31:0] f, input int n);
        vecs[i].base = b;  vecs[i].expo = e;  vecs[i].sint = si; vecs[i].sfrac = sf;
        vecs[i].err  = er; vecs[i].res  = r;  vecs[i].frac = f;  vecs[i].n_mul = n;
    endtask

    task automatic launch(input vec_t v);
        cur_expo = v.expo;
        cur_int  = v.sint;
        cur_frac = v.sfrac;
        @(negedge clk);
        base  = v.base;
        expo  = v.expo;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // waits for done; lat is the number of cycles after the start edge
    task automatic wait_done(input int limit, output int lat);
        lat = 1;
        while (!done && lat < limit) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int req0;
        int hs0;
        req0 = req_total;
        hs0  = hs_total;
        launch(v);
        wait_done(3000, lat);
        check({tag, ".done"}, 32'(done), 32'd1);
        if (v.err) check({tag, ".err_latency"}, 32'(lat), 32'd1);
        check({tag, ".err"},      32'(err), 32'(v.err));
        check({tag, ".result"},   result, v.res);
        check({tag, ".frac_out"}, frac_out, v.frac);
        check({tag, ".handshakes"}, 32'(hs_total - hs0), 32'(v.n_mul));
        check({tag, ".requests"},   32'(req_total - req0), 32'(v.n_mul));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".idle"},       32'(busy), 32'd0);
        check({tag, ".result_hold"}, result, v.res);
    endtask

    initial begin
        int lat;
        int cyc;
        int hi;
        int req0;
        int hs0;

        // 2^10, 3^3, error cases, boundary exponents, int==1 shortcut, single-bit int
        set_vec(0, 32'h4000_0000, 32'h4124_0000, 32'd10,  32'h3E80_0000, 1'b0, 32'h4480_0000, 32'h3E80_0000, 4);
        set_vec(1, 32'h4040_0000, 32'h4060_0000, 32'd3,   32'h3F00_0000, 1'b0, 32'h41D8_0000, 32'h3F00_0000, 2);
        set_vec(2, 32'h4000_0000, 32'h3F00_0000, 32'd0,   32'h3F00_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 0);
        set_vec(3, 32'h4000_0000, 32'hC120_0000, 32'd10,  32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 0);
        set_vec(4, 32'h3FC0_0000, 32'h4000_0000, 32'd2,   32'h0000_0000, 1'b0, 32'h4010_0000, 32'h0000_0000, 1);
        set_vec(5, 32'h4000_0000, 32'h42FE_0000, 32'd127, 32'h0000_0000, 1'b0, 32'h7F00_0000, 32'h0000_0000, 12);
        set_vec(6, 32'h4000_0000, 32'h4300_0000, 32'd0,   32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 0);
        set_vec(7, 32'hC000_0000, 32'h40A0_0000, 32'd5,   32'h0000_0000, 1'b0, 32'hC200_0000, 32'h0000_0000, 3);
        set_vec(8, 32'h4040_0000, 32'h4000_0000, 32'd1,   32'h0000_0000, 1'b0, 32'h4040_0000, 32'h0000_0000, 0);
        set_vec(9, 32'h4000_0000, 32'h4281_0000, 32'd64,  32'h3F00_0000, 1'b0, 32'h5F80_0000, 32'h3F00_0000, 6);

        repeat (3) @(negedge clk);
        check("reset.ctrl", {28'd0, busy, done, err, mul_req}, 32'd0);
        check("reset.split_ip", split_ip, 32'd0);
        check("reset.result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // start pulsed while the first square is in flight must be ignored
        req0 = req_total;
        hs0  = hs_total;
        launch(vecs[0]);
        cyc = 0;
        while (!mul_req && cyc < 50) begin @(negedge clk); cyc++; end
        check("restart.reached_sqr", 32'(mul_req), 32'd1);
        base  = 32'h4040_0000;
        expo  = 32'h4060_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, lat);
        check("restart.done", 32'(done), 32'd1);
        check("restart.result", result, 32'h4480_0000);
        check("restart.split_ip", split_ip, 32'h4124_0000);
        check("restart.handshakes", 32'(hs_total - hs0), 32'd4);
        check("restart.requests", 32'(req_total - req0), 32'd4);
        @(negedge clk);

        // random multiplier latency 0..5
        max_delay = 5;
        for (int k = 0; k < 3; k++) run_vec(vecs[0], $sformatf("rand%0d", k));
        run_vec(vecs[5], "rand_big");
        max_delay = 0;

        // reset while the MUL request (third of 2^10) is pending
        ack_base   = ack_total;
        ack_budget = 2;
        req0 = req_total;
        launch(vecs[0]);
        cyc = 0;
        while (!((req_total - req0) == 3 && mul_req) && cyc < 100) begin @(negedge clk); cyc++; end
        check("rst_mid.mul_req", 32'(mul_req), 32'd1);
        check("rst_mid.mul_a", mul_a, 32'h4180_0000);
        check("rst_mid.mul_b", mul_b, 32'h4000_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid.ctrl", {28'd0, busy, done, err, mul_req}, 32'd0);
        check("rst_mid.mul_ab", mul_a | mul_b, 32'd0);
        check("rst_mid.outs", result | frac_out | split_ip, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        ack_budget = -1;
        inject_ack = 1'b1;
        @(negedge clk);
        inject_ack = 1'b0;
        @(negedge clk);
        check("late_ack.ctrl", {28'd0, busy, done, err, mul_req}, 32'd0);
        run_vec(vecs[0], "after_rst");

        // multiplier never answers
        ack_base   = ack_total;
        ack_budget = 0;
        launch(vecs[0]);
        hi  = 0;
        cyc = 0;
        while (!done && cyc < 300) begin
            if (mul_req) hi++;
            @(negedge clk);
            cyc++;
        end
`ifdef POW_MUL_TIMEOUT_EN
        check("wd.done", 32'(done), 32'd1);
        check("wd.err", 32'(err), 32'd1);
        check("wd.result", result, 32'd0);
        check("wd.req_cycles", 32'(hi), 32'd63);
        check("wd.req_dropped", 32'(mul_req), 32'd0);
        @(negedge clk);
        check("wd.idle", 32'(busy), 32'd0);
`else
        check("stall.busy", 32'(busy), 32'd1);
        check("stall.req", 32'(mul_req), 32'd1);
        check("stall.no_done", 32'(done), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        ack_budget = -1;
        @(negedge clk);
        run_vec(vecs[1], "recover");

        check("protocol_violations", 32'(prot_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
